// File: rtl/rv_pkg.sv
// Shared RV32 decode constants: base opcodes and the immediate-select (extop)
// encoding that both this stage and the immediate generator switch on.
package rv_pkg;

    typedef logic [2:0] extop_t;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    localparam extop_t IMMI = 3'b000;
    localparam extop_t IMMU = 3'b001;
    localparam extop_t IMMS = 3'b010;
    localparam extop_t IMMB = 3'b011;
    localparam extop_t IMMJ = 3'b100;

endpackage

// File: rtl/opc_classify.sv
// Combinational opcode classifier: picks the immediate format and flags
// opcodes outside the RV32I base set.
module opc_classify
    import rv_pkg::*;
(
    input  logic [6:0] opcode,
    output extop_t     extop,
    output logic       illegal
);

    // Opcode to immediate-format / legality lookup
    always_comb begin
        extop   = IMMI;
        illegal = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                extop   = IMMU;
                illegal = 1'b0;
            end
            OPC_JAL: begin
                extop   = IMMJ;
                illegal = 1'b0;
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_MISCMEM, OPC_SYSTEM, OPC_OP: begin
                extop   = IMMI;
                illegal = 1'b0;
            end
            OPC_STORE: begin
                extop   = IMMS;
                illegal = 1'b0;
            end
            OPC_BRANCH: begin
                extop   = IMMB;
                illegal = 1'b0;
            end
            default: begin
                extop   = IMMI;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_decode_stage.sv
// Registered decode stage: one-entry output register behind a valid/ready
// handshake, presenting the opcode class and raw immediate fields.
module id_decode_stage
    import rv_pkg::*;
#(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   PC_RESET = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [11:0]     out_immI,
    output logic [11:0]     out_immS,
    output logic [11:0]     out_immB,
    output logic [19:0]     out_immU,
    output logic [19:0]     out_immJ,
    output logic [2:0]      out_extop,
    output logic            out_illegal
);

    logic            valid_r;
    logic [XLEN-1:0] inst_r;
    logic [XLEN-1:0] pc_r;
    extop_t          extop_r;
    logic            illegal_r;

    logic            ready_s;
    logic            accept_s;
    extop_t          cls_extop_s;
    logic            cls_illegal_s;

    opc_classify u_classify (
        .opcode  (in_inst[6:0]),
        .extop   (cls_extop_s),
        .illegal (cls_illegal_s)
    );

    // Ready is combinational from out_ready so a consumed entry can be replaced in the same cycle
    always_comb begin
        ready_s  = !valid_r || out_ready;
        accept_s = in_valid && ready_s && !flush;
    end

    // Output register; flush beats accept, and fields only move on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r   <= 1'b0;
            inst_r    <= '0;
            pc_r      <= PC_RESET;
            extop_r   <= IMMI;
            illegal_r <= 1'b0;
        end else if (flush) begin
            valid_r   <= 1'b0;
        end else if (accept_s) begin
            valid_r   <= 1'b1;
            inst_r    <= in_inst;
            pc_r      <= in_pc;
            extop_r   <= cls_extop_s;
            illegal_r <= cls_illegal_s;
        end else if (out_ready) begin
            valid_r   <= 1'b0;
        end else begin
            valid_r   <= valid_r;
        end
    end

    assign in_ready    = ready_s;
    assign out_valid   = valid_r;
    assign out_pc      = pc_r;
    assign out_extop   = extop_r;
    assign out_illegal = illegal_r;

    // Field slicing straight off the captured word; B/J drop their implicit zero LSB
    assign out_opcode  = inst_r[6:0];
    assign out_rd      = inst_r[11:7];
    assign out_rs1     = inst_r[19:15];
    assign out_rs2     = inst_r[24:20];
    assign out_funct3  = inst_r[14:12];
    assign out_funct7  = inst_r[31:25];
    assign out_immI    = inst_r[31:20];
    assign out_immS    = {inst_r[31:25], inst_r[11:7]};
    assign out_immB    = {inst_r[31], inst_r[7], inst_r[30:25], inst_r[11:8]};
    assign out_immU    = inst_r[31:12];
    assign out_immJ    = {inst_r[31], inst_r[19:12], inst_r[20], inst_r[30:21]};

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: a table of hand-decoded instructions
// streamed back to back, then stall, flush, drain and async-reset sequences.
module tb_id_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [11:0] out_immI;
    logic [11:0] out_immS;
    logic [11:0] out_immB;
    logic [19:0] out_immU;
    logic [19:0] out_immJ;
    logic [2:0]  out_extop;
    logic        out_illegal;

    int checks;
    int errors;

    id_decode_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_opcode  (out_opcode),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_immI    (out_immI),
        .out_immS    (out_immS),
        .out_immB    (out_immB),
        .out_immU    (out_immU),
        .out_immJ    (out_immJ),
        .out_extop   (out_extop),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind selects which immediate output the vector's exp_imm is compared with
    typedef enum logic [2:0] {K_I, K_S, K_B, K_U, K_J} kind_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        kind_t       kind;
        logic [19:0] imm;
        logic [2:0]  extop;
        logic        illegal;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] pick_imm(input kind_t k);
        case (k)
            K_I:     return {8'h00, out_immI};
            K_S:     return {8'h00, out_immS};
            K_B:     return {8'h00, out_immB};
            K_U:     return out_immU;
            K_J:     return out_immJ;
            default: return 20'hxxxxx;
        endcase
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        //          inst           pc            rd     rs1    rs2    f3    kind imm        extop   ill
        vecs[0]  = '{32'hFFF00093, 32'h00000100, 5'd1,  5'd0,  5'd31, 3'd0, K_I, 20'h00FFF, 3'b000, 1'b0};
        vecs[1]  = '{32'h0020A423, 32'h00000104, 5'd8,  5'd1,  5'd2,  3'd2, K_S, 20'h00008, 3'b010, 1'b0};
        vecs[2]  = '{32'hFE000EE3, 32'h00000108, 5'd29, 5'd0,  5'd0,  3'd0, K_B, 20'h00FFE, 3'b011, 1'b0};
        vecs[3]  = '{32'h123452B7, 32'h0000010C, 5'd5,  5'd8,  5'd3,  3'd5, K_U, 20'h12345, 3'b001, 1'b0};
        vecs[4]  = '{32'h008000EF, 32'h00000110, 5'd1,  5'd0,  5'd8,  3'd0, K_J, 20'h00004, 3'b100, 1'b0};
        vecs[5]  = '{32'h00000000, 32'h00000114, 5'd0,  5'd0,  5'd0,  3'd0, K_I, 20'h00000, 3'b000, 1'b1};
        vecs[6]  = '{32'h00001517, 32'h00000118, 5'd10, 5'd0,  5'd0,  3'd1, K_U, 20'h00001, 3'b001, 1'b0};
        vecs[7]  = '{32'h000080E7, 32'h0000011C, 5'd1,  5'd1,  5'd0,  3'd0, K_I, 20'h00000, 3'b000, 1'b0};
        vecs[8]  = '{32'h002081B3, 32'h00000120, 5'd3,  5'd1,  5'd2,  3'd0, K_I, 20'h00002, 3'b000, 1'b0};
        vecs[9]  = '{32'h0000007F, 32'h00000124, 5'd0,  5'd0,  5'd0,  3'd0, K_I, 20'h00000, 3'b000, 1'b1};
        vecs[10] = '{32'h00000073, 32'h00000128, 5'd0,  5'd0,  5'd0,  3'd0, K_I, 20'h00000, 3'b000, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = 32'h0;
        in_pc     = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #12;
        check("reset_valid",   {31'd0, out_valid},   32'd0);
        check("reset_pc",      out_pc,               32'h0);
        check("reset_extop",   {29'd0, out_extop},   32'd0);
        check("reset_illegal", {31'd0, out_illegal}, 32'd0);
        check("reset_immI",    {20'd0, out_immI},    32'd0);
        check("reset_ready",   {31'd0, in_ready},    32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back stream with out_ready high: every vector must land the cycle after it is offered
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_inst  = vecs[i].inst;
            in_pc    = vecs[i].pc;
            check($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i),   {31'd0, out_valid},     32'd1);
            check($sformatf("v%0d_pc", i),      out_pc,                 vecs[i].pc);
            check($sformatf("v%0d_opcode", i),  {25'd0, out_opcode},    {25'd0, vecs[i].inst[6:0]});
            check($sformatf("v%0d_rd", i),      {27'd0, out_rd},        {27'd0, vecs[i].rd});
            check($sformatf("v%0d_rs1", i),     {27'd0, out_rs1},       {27'd0, vecs[i].rs1});
            check($sformatf("v%0d_rs2", i),     {27'd0, out_rs2},       {27'd0, vecs[i].rs2});
            check($sformatf("v%0d_funct3", i),  {29'd0, out_funct3},    {29'd0, vecs[i].funct3});
            check($sformatf("v%0d_imm", i),     {12'd0, pick_imm(vecs[i].kind)}, {12'd0, vecs[i].imm});
            check($sformatf("v%0d_extop", i),   {29'd0, out_extop},     {29'd0, vecs[i].extop});
            check($sformatf("v%0d_illegal", i), {31'd0, out_illegal},   {31'd0, vecs[i].illegal});
        end
        check("sw_funct7_seen", {25'd0, out_funct7}, 32'd0);

        // Stall: LUI held for three cycles while a new ADDI waits
        @(negedge clk);
        in_inst = 32'h123452B7;
        in_pc   = 32'h00000180;
        @(posedge clk);
        #1;
        check("stall_load_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        in_inst   = 32'hFFF00093;
        in_pc     = 32'h00000200;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("stall%0d_valid", c), {31'd0, out_valid}, 32'd1);
            check($sformatf("stall%0d_immU", c),  {12'd0, out_immU},  32'h12345);
            check($sformatf("stall%0d_extop", c), {29'd0, out_extop}, 32'd1);
            check($sformatf("stall%0d_pc", c),    out_pc,             32'h180);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("release_pc",    out_pc,            32'h200);
        check("release_immI",  {20'd0, out_immI}, 32'h0FFF);
        check("release_valid", {31'd0, out_valid}, 32'd1);

        // Flush with a held entry and a same-cycle offer: nothing taken
        @(negedge clk);
        out_ready = 1'b0;
        flush     = 1'b1;
        in_inst   = 32'h0020A423;
        in_pc     = 32'h00000300;
        @(posedge clk);
        #1;
        check("flush_valid",   {31'd0, out_valid}, 32'd0);
        check("flush_not_taken_pc", out_pc,        32'h200);
        @(negedge clk);
        flush = 1'b0;
        @(posedge clk);
        #1;
        check("reoffer_valid", {31'd0, out_valid}, 32'd1);
        check("reoffer_pc",    out_pc,             32'h300);
        check("reoffer_immS",  {20'd0, out_immS},  32'h008);
        check("reoffer_extop", {29'd0, out_extop}, 32'd2);

        // Drain: consume with no new input empties the register
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk);
        #1;
        check("drain_valid", {31'd0, out_valid}, 32'd0);

        // Async reset between edges while an entry is stalled
        @(negedge clk);
        in_valid  = 1'b1;
        in_inst   = 32'h008000EF;
        in_pc     = 32'h00000400;
        @(posedge clk);
        #1;
        check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", {31'd0, out_valid}, 32'd0);
        check("async_reset_pc",    out_pc,             32'h0);
        check("async_reset_extop", {29'd0, out_extop}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_idle", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
- Registered instruction-decode stage between instruction fetch and the immediate generator / execute stage.
- Accepts a fetched instruction and PC over a valid/ready handshake.
- Classifies the opcode, slices the raw immediate fields in the layout the immediate generator consumes, and selects `extop`.
- Presents everything from a one-entry output register, with stall back-pressure, flush, and illegal-opcode flagging.

Parameters:
- XLEN, 32, PC and instruction width (only 32 is supported).
- PC_RESET, 32'h0000_0000, value of `out_pc` after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  32  PC of `in_inst`.
- flush  in  1  discard the held entry and any same-cycle input.
- out_valid  out  1  output register holds a decoded instruction.
- out_ready  in  1  downstream consumes this cycle.
- out_pc  out  32  registered PC.
- out_opcode  out  7  `inst[6:0]`.
- out_rd  out  5  `inst[11:7]`.
- out_rs1  out  5  `inst[19:15]`.
- out_rs2  out  5  `inst[24:20]`.
- out_funct3  out  3  `inst[14:12]`.
- out_funct7  out  7  `inst[31:25]`.
- out_immI  out  12  `inst[31:20]`.
- out_immS  out  12  `{inst[31:25], inst[11:7]}`.
- out_immB  out  12  `{inst[31], inst[7], inst[30:25], inst[11:8]}`; the LSB zero is appended downstream.
- out_immU  out  20  `inst[31:12]`.
- out_immJ  out  20  `{inst[31], inst[19:12], inst[20], inst[30:21]}`; the LSB zero is appended downstream.
- out_extop  out  3  immediate select.
- out_illegal  out  1  opcode not recognised.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - `out_valid` = 0, `out_pc` = PC_RESET.
  - All other outputs = 0, so `out_extop` = 3'b000.
- Handshake:
  - `in_ready = !out_valid || out_ready`. This is a combinational path from `out_ready`.
  - Accept when `in_valid && in_ready && !flush`.
  - On accept, all output fields load on the next edge and `out_valid` = 1. Latency is 1 cycle from accept to `out_valid`.
  - When `out_valid && out_ready` with no accept, `out_valid` goes to 0.
  - Simultaneous consume and accept: the register reloads and `out_valid` stays 1. Full throughput is 1 instruction/cycle.
  - While `out_valid && !out_ready`, all outputs are held stable and `in_ready` = 0.
- Flush has priority over everything: the next edge gives `out_valid` = 0 and no input is accepted. Field registers may keep stale data.
- Field registers update only on accept; `out_valid` gates their meaning.
- extop encoding (shared package):
  - IMMI = 000, IMMU = 001, IMMS = 010, IMMB = 011, IMMJ = 100.
- Opcode to extop / illegal mapping:
  - 0110111 LUI, 0010111 AUIPC → IMMU.
  - 1101111 JAL → IMMJ.
  - 1100111 JALR, 0000011 LOAD, 0010011 OP-IMM, 0001111 MISC-MEM, 1110011 SYSTEM → IMMI.
  - 0100011 STORE → IMMS.
  - 1100011 BRANCH → IMMB.
  - 0110011 OP → IMMI; the immediate is unused.
  - Any other opcode → IMMI with `out_illegal` = 1. It still travels as a valid entry; downstream raises the trap.
- Slicing is pure wiring of `in_inst` captured at accept. No sign extension here.
- Reset asserted mid-stall drops the held entry immediately (asynchronous).

Decomposition:
- Package `rv_pkg`:
  - opcode localparams (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_MISCMEM, OPC_SYSTEM).
  - extop localparams IMMI..IMMJ; the immediate generator switches to these too.
  - typedef `extop_t` logic[2:0].
- One combinational sub-module `opc_classify`: opcode in, `extop` + `illegal` out.
- Register, handshake and field slicing stay in the top module.

Test Plan:
- Reset and a single ADDI:
  - Stimulus: reset, then `in_inst`=32'hFFF00093, `in_pc`=32'h100 with `out_ready`=1.
  - Response: next cycle `out_valid`=1, `out_immI`=12'hFFF, `out_rd`=1, `out_extop`=000, `out_illegal`=0, `out_pc`=32'h100.
- Back-to-back SW then BEQ:
  - Stimulus: 32'h0020A423 followed by 32'hFE000EE3.
  - Response: first output has `out_immS`=12'h008, `out_extop`=010, `out_rs1`=1, `out_rs2`=2. Next cycle `out_immB`=12'hFFE, `out_extop`=011.
  - No bubble between them.
- Stall:
  - Stimulus: LUI 32'h123452B7 accepted, then hold `out_ready`=0 for 3 cycles.
  - Response: `out_immU`=20'h12345 and `out_extop`=001 held; `in_ready`=0 throughout. Releasing `out_ready` lets the next instruction issue in the same cycle.
- Flush:
  - Stimulus: `flush`=1 while `out_valid`=1 and `in_valid`=1.
  - Response: next cycle `out_valid`=0 and the input is not taken. It is re-presented and accepted after `flush` drops.
- Illegal plus JAL:
  - Stimulus: 32'h00000000.
  - Response: `out_illegal`=1, `out_extop`=000.
  - Stimulus: JAL x1,+8 (32'h008000EF).
  - Response: `out_immJ`=20'h00004, `out_extop`=100.
- Async reset mid-stall:
  - Stimulus: assert `rst_n`=0 between clock edges while an entry is held.
  - Response: `out_valid` goes to 0 without waiting for a clock edge.
